// File: rtl/uart_transmitter.sv
// UART transmit stage: serialises one DBITS-wide word per tx_start as
// start bit, data LSB-first, parity bit, stop bit. Bit timing comes from
// the shared 16x-oversampling baud tick. tx is always driven from a flop.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for tx_start
// S_START  | start bit (tx = 0) for OS_TICKS ticks
// S_DATA   | data bits LSB-first, OS_TICKS ticks each
// S_PARITY | parity bit latched at acceptance
// S_STOP   | stop bit (tx = 1); tx_done on its final tick
module uart_transmitter #(
  parameter int DBITS      = 3,
  parameter int PARITY_ODD = 0,
  parameter int OS_TICKS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             tx_start,
  input  logic [DBITS-1:0] din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int         BW       = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [3:0] CNT_LAST = 4'(OS_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [3:0]       tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [DBITS-1:0] shift_reg;
  logic [DBITS-1:0] shift_nx;
  logic             par_reg;
  logic             par_calc;
  logic             tx_reg;
  logic             bit_end;

  // The current serial bit finishes on the tick that completes its count.
  assign bit_end  = tick && (tick_cnt == CNT_LAST);
  assign shift_nx = shift_reg >> 1;
  assign par_calc = (^din) ^ (PARITY_ODD != 0);

  // Frame sequencer: state, tick/bit counters, shift register and tx flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx_reg <= 1'b1;
          if (tx_start) begin
            shift_reg <= din;
            par_reg   <= par_calc;
            tick_cnt  <= '0;
            tx_reg    <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_reg   <= shift_reg[0];
            state    <= S_DATA;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              tx_reg <= par_reg;
              state  <= S_PARITY;
            end else begin
              shift_reg <= shift_nx;
              tx_reg    <= shift_nx[0];
              bit_cnt   <= bit_cnt + BW'(1);
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tick_cnt <= '0;
            tx_reg   <= 1'b1;
            state    <= S_STOP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            tick_cnt <= '0;
            tx_reg   <= 1'b1;
            state    <= S_IDLE;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
          end
        end
        default: begin
          tx_reg <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Status decoded from the state register; tx_done marks the last stop tick.
  assign tx      = tx_reg;
  assign tx_busy = (state != S_IDLE);
  assign tx_done = (state == S_STOP) && bit_end;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: an even-parity and an odd-parity instance share
// all inputs; a line monitor decodes each tx against a queue of expected frames.
module tb_uart_transmitter;

  localparam int DBITS = 3;
  localparam int FW    = DBITS + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             tx_start = 1'b0;
  logic [DBITS-1:0] din = '0;
  logic             tx_e, tx_busy_e, tx_done_e;
  logic             tx_o, tx_busy_o, tx_done_o;

  int vectors = 0;
  int errors  = 0;

  logic          tick_en = 1'b0;
  int            div = 0;

  logic [FW-1:0] q_even[$];
  logic [FW-1:0] q_odd[$];
  logic [FW-1:0] cur[2];
  bit            mon_act[2];
  int            mon_cnt[2];
  int            frames_done[2];

  logic          mtx, mbusy, mdone, mexp_done;

  uart_transmitter #(.DBITS(DBITS), .PARITY_ODD(0), .OS_TICKS(16)) dut_even (
    .clk(clk), .rst(rst), .tick(tick), .tx_start(tx_start), .din(din),
    .tx(tx_e), .tx_busy(tx_busy_e), .tx_done(tx_done_e)
  );

  uart_transmitter #(.DBITS(DBITS), .PARITY_ODD(1), .OS_TICKS(16)) dut_odd (
    .clk(clk), .rst(rst), .tick(tick), .tx_start(tx_start), .din(din),
    .tx(tx_o), .tx_busy(tx_busy_o), .tx_done(tx_done_o)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk wide, every 4th clk while enabled.
  always @(posedge clk) begin
    #2;
    if (tick_en) begin
      div  = (div + 1) % 4;
      tick = (div == 0);
    end else begin
      tick = 1'b0;
    end
  end

  // Expected frame bit sequence: index 0 = start, then data LSB-first, parity, stop.
  function automatic logic [FW-1:0] mk_frame(input logic [DBITS-1:0] d, input logic odd);
    return {1'b1, (^d) ^ odd, d, 1'b0};
  endfunction

  // Line monitor / scoreboard for both instances.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      mtx   = (c == 0) ? tx_e      : tx_o;
      mbusy = (c == 0) ? tx_busy_e : tx_busy_o;
      mdone = (c == 0) ? tx_done_e : tx_done_o;
      if (!rst) begin
        mon_act[c] = 1'b0;
        mon_cnt[c] = 0;
        if (c == 0) q_even.delete(); else q_odd.delete();
        vectors++;
        if (mtx !== 1'b1 || mbusy !== 1'b0 || mdone !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs ch%0d: tx=%b busy=%b done=%b, required 1 0 0", c, mtx, mbusy, mdone);
        end
      end else begin
        if (!mon_act[c] && mtx === 1'b0) begin
          vectors++;
          if ((c == 0 && q_even.size() == 0) || (c == 1 && q_odd.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_frame ch%0d at %0t: frame started with nothing queued", c, $time);
            cur[c] = '1;
          end else begin
            cur[c] = (c == 0) ? q_even.pop_front() : q_odd.pop_front();
          end
          mon_act[c] = 1'b1;
          mon_cnt[c] = 0;
        end
        mexp_done = mon_act[c] && tick && (mon_cnt[c] == 16 * FW - 1);
        vectors++;
        if (mon_act[c] && mtx !== cur[c][mon_cnt[c] / 16]) begin
          errors++;
          $display("FAIL tx_bit ch%0d bit%0d tick%0d: tx=%b, required %b", c, mon_cnt[c] / 16, mon_cnt[c],
                   mtx, cur[c][mon_cnt[c] / 16]);
        end else if (!mon_act[c] && mtx !== 1'b1) begin
          errors++;
          $display("FAIL tx_idle ch%0d: tx=%b, required 1", c, mtx);
        end
        vectors++;
        if (mbusy !== mon_act[c]) begin
          errors++;
          $display("FAIL tx_busy ch%0d at %0t: busy=%b, required %b", c, $time, mbusy, mon_act[c]);
        end
        vectors++;
        if (mdone !== mexp_done) begin
          errors++;
          $display("FAIL tx_done ch%0d at %0t tick%0d: done=%b, required %b", c, $time, mon_cnt[c], mdone, mexp_done);
        end
        if (mon_act[c] && tick) mon_cnt[c]++;
        if (mexp_done) begin
          mon_act[c] = 1'b0;
          frames_done[c]++;
        end
      end
    end
  end

  // Start a frame from idle: tx_start for one clk, expectation queued.
  task automatic send(input logic [DBITS-1:0] d);
    @(posedge clk); #1;
    din      = d;
    tx_start = 1'b1;
    q_even.push_back(mk_frame(d, 1'b0));
    q_odd.push_back(mk_frame(d, 1'b1));
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (tick) seen++;
    end
    vectors++;
    if (seen < n) begin
      errors++;
      $display("FAIL wait_ticks: saw %0d ticks, required %0d", seen, n);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((mon_act[0] || mon_act[1] || q_even.size() != 0 || q_odd.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 3000) begin
      errors++;
      $display("FAIL wait_idle: frame still pending after %0d clks", guard);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick_en = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx_e !== 1'b1 || tx_busy_e !== 1'b0 || tx_done_e !== 1'b0) begin
      errors++;
      $display("FAIL test_reset: tx=%b busy=%b done=%b, required 1 0 0", tx_e, tx_busy_e, tx_done_e);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int f0 = frames_done[0];
    send(3'b101);
    wait_idle();
    vectors++;
    if (frames_done[0] - f0 !== 1) begin
      errors++;
      $display("FAIL basic_frame_count: %0d frames, required 1", frames_done[0] - f0);
    end
  endtask

  task automatic test_loopback();
    int f0 = frames_done[1];
    for (int d = 0; d < 8; d++) begin
      send(DBITS'(d));
      wait_idle();
    end
    vectors++;
    if (frames_done[1] - f0 !== 8) begin
      errors++;
      $display("FAIL loopback_count: %0d odd-parity frames, required 8", frames_done[1] - f0);
    end
  endtask

  task automatic test_ignore_start();
    int f0 = frames_done[0];
    send(3'b000);
    wait_ticks(19);
    @(posedge clk); #1 tx_start = 1'b1; din = 3'b111;
    @(posedge clk); #1 tx_start = 1'b0;
    wait_ticks(29);
    @(posedge clk); #1 tx_start = 1'b1; din = 3'b110;
    @(posedge clk); #1 tx_start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    vectors++;
    if (frames_done[0] - f0 !== 1 || tx_busy_e !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: %0d frames busy=%b, required 1 frame busy=0", frames_done[0] - f0, tx_busy_e);
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    @(posedge clk); #1;
    din      = 3'b110;
    tx_start = 1'b1;
    q_even.push_back(mk_frame(3'b110, 1'b0));
    q_odd.push_back(mk_frame(3'b110, 1'b1));
    q_even.push_back(mk_frame(3'b001, 1'b0));
    q_odd.push_back(mk_frame(3'b001, 1'b1));
    @(posedge clk); #1 din = 3'b001;
    while (tx_done_e !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL back_to_back_done: no tx_done within %0d clks", guard);
    end
    @(negedge clk);
    vectors++;
    if (tx_busy_e !== 1'b0 || tx_e !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_gap: busy=%b tx=%b, required 0 1", tx_busy_e, tx_e);
    end
    @(posedge clk); #1 tx_start = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_busy_e !== 1'b1 || tx_e !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_restart: busy=%b tx=%b, required 1 0", tx_busy_e, tx_e);
    end
    wait_idle();
  endtask

  task automatic test_tick_pause();
    logic held;
    send(3'b110);
    wait_ticks(37);
    @(posedge clk); #1 tick_en = 1'b0;
    @(negedge clk);
    held = tx_e;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (tx_e !== held || tx_o !== held || tx_busy_e !== 1'b1) begin
        errors++;
        $display("FAIL tick_pause clk%0d: tx=%b/%b busy=%b, required %b/%b 1", i, tx_e, tx_o, tx_busy_e, held, held);
      end
    end
    @(posedge clk); #1 tick_en = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_abort();
    int f0 = frames_done[0];
    send(3'b010);
    wait_ticks(69);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    vectors++;
    if (tx_e !== 1'b1 || tx_busy_e !== 1'b0 || tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_async: tx=%b/%b busy=%b/%b, required 1/1 0/0", tx_e, tx_o, tx_busy_e, tx_busy_o);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (60) @(negedge clk);
    vectors++;
    if (frames_done[0] !== f0 || tx_busy_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_idle: frames=%0d busy=%b, required %0d 0", frames_done[0], tx_busy_e, f0);
    end
    send(3'b111);
    wait_idle();
  endtask

  task automatic test_din_change();
    send(3'b011);
    @(posedge clk); #1 din = 3'b100;
    wait_idle();
  endtask

  initial begin
    frames_done[0] = 0;
    frames_done[1] = 0;
    mon_act[0] = 1'b0;
    mon_act[1] = 1'b0;
    mon_cnt[0] = 0;
    mon_cnt[1] = 0;
    test_reset();
    test_basic_frame();
    test_loopback();
    test_ignore_start();
    test_back_to_back();
    test_tick_pause();
    test_reset_abort();
    test_din_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
